adc_scan_ctrl: RTL and testbench

//  Sequencer for the board's LTC2308 8-channel 12-bit SPI ADC (ADC_CONVST/SCLK/DIN/DOUT pins).

---
 rtl/adc_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer for an LTC2308 8-channel 12-bit SPI ADC.
// Each result is tagged with the channel that was programmed one frame earlier.
module adc_scan_ctrl #(
   parameter int CLK_DIV       = 2,
   parameter int CONVST_CYCLES = 2,
   parameter int CONV_CYCLES   = 80,
   parameter int ACQ_CYCLES    = 12
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        enable,
   input  logic [7:0]  ch_mask,
   output logic        ADC_CONVST,
   output logic        ADC_SCLK,
   output logic        ADC_DIN,
   input  logic        ADC_DOUT,
   output logic        busy,
   output logic        result_valid,
   output logic [2:0]  result_ch,
   output logic [11:0] result_data
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CONVST = 3'd1,
      S_CONV   = 3'd2,
      S_SHIFT  = 3'd3,
      S_ACQ    = 3'd4
   } state_t;

   state_t      state_r;
   logic [15:0] cnt_r;
   logic [3:0]  bit_cnt_r;
   logic [2:0]  cfg_ch_r;
   logic [2:0]  conv_ch_r;
   logic        prime_r;
   logic [4:0]  din_sh_r;
   logic [11:0] data_sh_r;
   logic [5:0]  cfg_word_s;

   function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
      logic [2:0] ch;
      ch = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) ch = 3'(i);
      end
      return ch;
   endfunction

   // Lowest set bit strictly above cur, wrapping; cur itself is the last candidate.
   function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] mask);
      logic [2:0] ch;
      logic [2:0] idx;
      logic       found;
      ch    = cur;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         idx = cur + 3'(i);
         if (!found && mask[idx]) begin
            ch    = idx;
            found = 1'b1;
         end
      end
      return ch;
   endfunction

   // S/D=1 (single-ended), O/S, S1, S0, UNI=1, SLP=0
   function automatic logic [5:0] cfg_word(input logic [2:0] ch);
      return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
   endfunction

   // Config word for the channel to be programmed in the coming frame.
   always_comb begin
      cfg_word_s = cfg_word(cfg_ch_r);
   end

   // Frame sequencer; every ADC pin and result output is driven from here.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_r      <= S_IDLE;
         cnt_r        <= 16'd0;
         bit_cnt_r    <= 4'd0;
         cfg_ch_r     <= 3'd0;
         conv_ch_r    <= 3'd0;
         prime_r      <= 1'b0;
         din_sh_r     <= 5'd0;
         data_sh_r    <= 12'd0;
         ADC_CONVST   <= 1'b0;
         ADC_SCLK     <= 1'b0;
         ADC_DIN      <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result_ch    <= 3'd0;
         result_data  <= 12'd0;
      end else begin
         result_valid <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (enable && (ch_mask != 8'h00)) begin
                  state_r    <= S_CONVST;
                  cnt_r      <= 16'd0;
                  ADC_CONVST <= 1'b1;
                  busy       <= 1'b1;
                  cfg_ch_r   <= lowest_ch(ch_mask);
                  prime_r    <= 1'b0;
               end
            end
            S_CONVST: begin
               if (cnt_r == 16'(CONVST_CYCLES - 1)) begin
                  state_r    <= S_CONV;
                  cnt_r      <= 16'd0;
                  ADC_CONVST <= 1'b0;
                  ADC_DIN    <= cfg_word_s[5];
                  din_sh_r   <= cfg_word_s[4:0];
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            S_CONV: begin
               if (cnt_r == 16'(CONV_CYCLES - 1)) begin
                  state_r   <= S_SHIFT;
                  cnt_r     <= 16'd0;
                  bit_cnt_r <= 4'd0;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            S_SHIFT: begin
               if (cnt_r == 16'(CLK_DIV - 1)) begin
                  cnt_r <= 16'd0;
                  if (!ADC_SCLK) begin
                     ADC_SCLK  <= 1'b1;
                     data_sh_r <= {data_sh_r[10:0], ADC_DOUT};
                  end else begin
                     // DIN only moves on the falling edge; zeros fill after the 6-bit word.
                     ADC_SCLK <= 1'b0;
                     ADC_DIN  <= din_sh_r[4];
                     din_sh_r <= {din_sh_r[3:0], 1'b0};
                     if (bit_cnt_r == 4'd11) begin
                        state_r      <= S_ACQ;
                        result_valid <= prime_r;
                        if (prime_r) begin
                           result_ch   <= conv_ch_r;
                           result_data <= data_sh_r;
                        end
                        prime_r   <= 1'b1;
                        conv_ch_r <= cfg_ch_r;
                        cfg_ch_r  <= next_ch(cfg_ch_r, ch_mask);
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                     end
                  end
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            S_ACQ: begin
               // Entry cycle plus ACQ_CYCLES of acquisition gap.
               if (cnt_r == 16'(ACQ_CYCLES)) begin
                  cnt_r <= 16'd0;
                  if (enable && (ch_mask != 8'h00)) begin
                     state_r    <= S_CONVST;
                     ADC_CONVST <= 1'b1;
                  end else begin
                     state_r <= S_IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               state_r    <= S_IDLE;
               cnt_r      <= 16'd0;
               ADC_CONVST <= 1'b0;
               ADC_SCLK   <= 1'b0;
               ADC_DIN    <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl with a behavioural LTC2308 model
// that applies the received config word to the following conversion.
module tb_adc_scan_ctrl;

   localparam int FRAME       = 143;
   localparam int FIRST_PULSE = 273;
   localparam int SCLK_PERIOD = 4;

   logic        clk     = 1'b0;
   logic        RESET   = 1'b1;
   logic        enable  = 1'b0;
   logic [7:0]  ch_mask = 8'h00;
   logic        ADC_CONVST, ADC_SCLK, ADC_DIN, busy, result_valid;
   logic        ADC_DOUT = 1'b0;
   logic [2:0]  result_ch;
   logic [11:0] result_data;

   adc_scan_ctrl dut (
      .CLOCK_50(clk), .RESET(RESET), .enable(enable), .ch_mask(ch_mask),
      .ADC_CONVST(ADC_CONVST), .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN), .ADC_DOUT(ADC_DOUT),
      .busy(busy), .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: mode 0 -> A00+ch, 1 -> 111*(ch+1), 2 -> FFF, 3 -> 000
   logic [1:0] mode = 2'd0;

   function automatic logic [11:0] model_data(input logic [1:0] m, input logic [2:0] ch);
      case (m)
         2'd0:    return 12'hA00 + {9'd0, ch};
         2'd1:    return 12'h111 * ({9'd0, ch} + 12'd1);
         2'd2:    return 12'hFFF;
         default: return 12'h000;
      endcase
   endfunction

   int          m_falls = 0, m_rises = 0;
   logic        m_prev_convst = 1'b0, m_prev_sclk = 1'b0;
   logic [5:0]  m_cap = 6'd0;
   logic [2:0]  m_cfg_ch = 3'd0, m_conv_ch = 3'd0;
   logic [11:0] m_word;

   // ADC pin behaviour: DIN latched on SCLK rise, DOUT advances after SCLK fall.
   always @(negedge clk) begin
      if (ADC_CONVST && !m_prev_convst) begin
         m_falls   = 0;
         m_rises   = 0;
         m_conv_ch = m_cfg_ch;
      end
      if (ADC_SCLK && !m_prev_sclk) begin
         if (m_rises < 6) m_cap = {m_cap[4:0], ADC_DIN};
         m_rises++;
         if (m_rises == 6) m_cfg_ch = {m_cap[3], m_cap[2], m_cap[4]};
      end
      if (!ADC_SCLK && m_prev_sclk) m_falls++;
      m_prev_convst = ADC_CONVST;
      m_prev_sclk   = ADC_SCLK;
      m_word        = model_data(mode, m_conv_ch);
      ADC_DOUT      = (m_falls < 12) ? m_word[4'(11 - m_falls)] : 1'b0;
   end

   // Observers: result pulses, CONVST starts, SCLK/DIN timing.
   typedef struct packed { logic [2:0] ch; logic [11:0] data; int cyc; } pulse_t;
   pulse_t pq[$];
   int     convst_q[$];
   logic   prev_sclk = 1'b0, prev_din = 1'b0, prev_convst = 1'b0;
   int     rise_idx = 0, last_rise_count = 0, convst_hi = 0, last_convst_width = 0;
   int     din_unstable = 0, period_err = 0, din_late_err = 0, last_rise_cyc = 0;
   logic [5:0] din_word = 6'd0;

   always @(negedge clk) begin
      if (result_valid) pq.push_back('{ch: result_ch, data: result_data, cyc: cyc});
      if (ADC_CONVST && !prev_convst) begin
         convst_q.push_back(cyc);
         last_rise_count = rise_idx;
         rise_idx  = 0;
         convst_hi = 0;
      end
      if (ADC_CONVST) convst_hi++;
      if (!ADC_CONVST && prev_convst) last_convst_width = convst_hi;
      if (ADC_SCLK && prev_sclk && (ADC_DIN != prev_din)) din_unstable++;
      if (ADC_SCLK && !prev_sclk) begin
         rise_idx++;
         if (rise_idx <= 6) din_word = {din_word[4:0], ADC_DIN};
         else if (ADC_DIN) din_late_err++;
         if (rise_idx > 1 && (cyc - last_rise_cyc) != SCLK_PERIOD) period_err++;
         last_rise_cyc = cyc;
      end
      prev_sclk   = ADC_SCLK;
      prev_din    = ADC_DIN;
      prev_convst = ADC_CONVST;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      RESET  = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      RESET = 1'b0;
      pq.delete();
      convst_q.delete();
      din_unstable = 0;
      period_err   = 0;
      din_late_err = 0;
   endtask

   task automatic wait_pulses(input int n, input int budget, input string name);
      int k = 0;
      while (pq.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({name, " pulse count"}, 32'(pq.size() >= n), 32'd1);
   endtask

   task automatic wait_sclk_high(input string name);
      int k = 0;
      while (ADC_SCLK !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      check({name, " reach shift"}, 32'(k < 400), 32'd1);
   endtask

   function automatic logic [19:0] out_vec();
      return {ADC_CONVST, ADC_SCLK, ADC_DIN, busy, result_valid, result_ch, result_data};
   endfunction

   // ch/d index 0 is the first result pulse (listed last in the concatenation).
   typedef struct packed {
      logic [1:0]        mode;
      logic [7:0]        mask;
      logic [2:0][2:0]   ch;
      logic [2:0][11:0]  d;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int cv, cq_base;
      logic [2:0]  exp_ch [3];
      logic [11:0] exp_d  [3];

      vecs[0] = '{mode: 2'd0, mask: 8'h05, ch: {3'd0, 3'd2, 3'd0}, d: {12'hA00, 12'hA02, 12'hA00}};
      vecs[1] = '{mode: 2'd1, mask: 8'h80, ch: {3'd7, 3'd7, 3'd7}, d: {12'h888, 12'h888, 12'h888}};
      vecs[2] = '{mode: 2'd2, mask: 8'h01, ch: {3'd0, 3'd0, 3'd0}, d: {12'hFFF, 12'hFFF, 12'hFFF}};
      vecs[3] = '{mode: 2'd3, mask: 8'h06, ch: {3'd1, 3'd2, 3'd1}, d: {12'h000, 12'h000, 12'h000}};
      vecs[4] = '{mode: 2'd0, mask: 8'h90, ch: {3'd4, 3'd7, 3'd4}, d: {12'hA04, 12'hA07, 12'hA04}};

      // Table: reset state, priming latency, tags, data and frame spacing.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         check($sformatf("v%0d reset outputs", i), 32'(out_vec()), 32'd0);
         mode    = vecs[i].mode;
         ch_mask = vecs[i].mask;
         enable  = 1'b1;
         wait_pulses(3, 900, $sformatf("v%0d", i));
         if (pq.size() >= 3 && convst_q.size() >= 2) begin
            check($sformatf("v%0d first pulse delay", i), 32'(pq[0].cyc - convst_q[0]), 32'(FIRST_PULSE));
            check($sformatf("v%0d convst period", i), 32'(convst_q[1] - convst_q[0]), 32'(FRAME));
            for (int j = 0; j < 3; j++) begin
               check($sformatf("v%0d p%0d ch", i, j), 32'(pq[j].ch), 32'(vecs[i].ch[j]));
               check($sformatf("v%0d p%0d data", i, j), 32'(pq[j].data), 32'(vecs[i].d[j]));
               if (j > 0) check($sformatf("v%0d p%0d spacing", i, j), 32'(pq[j].cyc - pq[j-1].cyc), 32'(FRAME));
            end
         end
      end

      // Bit level on channel 7.
      do_reset();
      mode = 2'd0; ch_mask = 8'h80; enable = 1'b1;
      begin
         int k = 0;
         while (convst_q.size() < 3 && k < 500) begin @(negedge clk); k++; end
         check("bit convst count", 32'(convst_q.size() >= 3), 32'd1);
      end
      check("bit din word", 32'(din_word), 32'(6'b111110));
      check("bit sclk pulses", 32'(last_rise_count), 32'd12);
      check("bit convst width", 32'(last_convst_width), 32'd2);
      check("bit din stable hi", 32'(din_unstable), 32'd0);
      check("bit sclk period", 32'(period_err), 32'd0);
      check("bit din late zero", 32'(din_late_err), 32'd0);

      // Mask change during SHIFT keeps the tag pipeline correct.
      do_reset();
      mode = 2'd1; ch_mask = 8'h01; enable = 1'b1;
      wait_pulses(1, 600, "mask first");
      pq.delete();
      wait_sclk_high("mask");
      ch_mask = 8'h02;
      wait_pulses(3, 700, "mask");
      exp_ch = '{3'd0, 3'd0, 3'd1};
      exp_d  = '{12'h111, 12'h111, 12'h222};
      if (pq.size() >= 3) begin
         for (int j = 0; j < 3; j++) begin
            check($sformatf("mask p%0d ch", j), 32'(pq[j].ch), 32'(exp_ch[j]));
            check($sformatf("mask p%0d data", j), 32'(pq[j].data), 32'(exp_d[j]));
         end
      end

      // Enable dropped during CONV of a primed frame.
      do_reset();
      mode = 2'd0; ch_mask = 8'h05; enable = 1'b1;
      wait_pulses(1, 600, "stop primed");
      pq.delete();
      begin
         int k = 0;
         while (ADC_CONVST !== 1'b1 && k < 300) begin @(negedge clk); k++; end
         while (ADC_CONVST !== 1'b0 && k < 300) begin @(negedge clk); k++; end
         check("stop reach conv", 32'(k < 300), 32'd1);
      end
      repeat (10) @(negedge clk);
      enable = 1'b0;
      cv = convst_q.size();
      repeat (400) @(negedge clk);
      check("stop pulses", 32'(pq.size()), 32'd1);
      if (pq.size() >= 1) begin
         check("stop last ch", 32'(pq[0].ch), 32'd2);
         check("stop last data", 32'(pq[0].data), 32'hA02);
      end
      check("stop busy", 32'(busy), 32'd0);
      check("stop no convst", 32'(convst_q.size()), 32'(cv));
      pq.delete();
      cq_base = convst_q.size();
      enable  = 1'b1;
      wait_pulses(1, 600, "restart");
      if (pq.size() >= 1 && convst_q.size() > cq_base) begin
         check("restart priming delay", 32'(pq[0].cyc - convst_q[cq_base]), 32'(FIRST_PULSE));
         check("restart ch", 32'(pq[0].ch), 32'd0);
      end

      // Reset mid-SHIFT, then an empty mask.
      do_reset();
      mode = 2'd0; ch_mask = 8'h05; enable = 1'b1;
      wait_pulses(2, 800, "rst pre");
      wait_sclk_high("rst");
      RESET = 1'b1;
      @(negedge clk);
      check("rst outputs", 32'(out_vec()), 32'd0);
      enable = 1'b0;
      RESET  = 1'b0;
      pq.delete();
      repeat (300) @(negedge clk);
      check("rst no result", 32'(pq.size()), 32'd0);
      ch_mask = 8'h00;
      enable  = 1'b1;
      cv = convst_q.size();
      repeat (200) @(negedge clk);
      check("mask0 busy", 32'(busy), 32'd0);
      check("mask0 no convst", 32'(convst_q.size()), 32'(cv));

      // Full mask: tags 0..7 then wrap to 0.
      do_reset();
      mode = 2'd0; ch_mask = 8'hFF; enable = 1'b1;
      wait_pulses(9, 1800, "all");
      if (pq.size() >= 9) begin
         for (int j = 0; j < 9; j++) begin
            check($sformatf("all p%0d ch", j), 32'(pq[j].ch), 32'(j % 8));
            check($sformatf("all p%0d data", j), 32'(pq[j].data), 32'(12'hA00 + 12'(j % 8)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
